idu_stage: RTL and testbench

- Decode stage directly downstream of the fetch unit.
- Captures each fetched (pc, instr) pair into a single-entry pipeline register using a valid/ready handshake.
- Decodes the held instruction as RV32I: register indices, function fields, sign-extended immediate, illegal flag.
- Presents the result to the execute stage under a second valid/ready handshake; honours a flush from a taken branch.

---
 rtl/idu_stage.sv | 180 ++++++++++++++++++
 tb/tb_idu_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/idu_stage.sv
// ---------------------------------------------------------------------------
// idu_stage -- RV32I decode stage with a single-entry pipeline register.
//
// The fetch unit offers a (pc, instr) pair under a valid/ready handshake. The
// stage holds one entry and decodes it combinationally. The entry goes to
// execute under a second valid/ready handshake. A flush from a taken branch
// kills both the held entry and any entry offered in the same cycle.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   ifu_valid  fetch offers pc_in / instr_in
//   idu_ready  stage can accept this cycle (combinational from exu_ready)
//   pc_in      pc of the offered instruction
//   instr_in   offered instruction word
//   flush      taken branch: drop the held and the incoming instruction
//   exu_ready  execute accepts this cycle
//   idu_valid  decoded instruction available
//   pc_out     held pc
//   instr_out  held instruction word
//   opcode, rd, rs1, rs2, funct3, funct7   raw instruction fields
//   imm        sign-extended immediate
//   imm_type   0=none 1=I 2=S 3=B 4=U 5=J
//   reg_wen    instruction writes a non-zero rd
//   illegal    unrecognised encoding (meaningful only while idu_valid)
// ---------------------------------------------------------------------------
module idu_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ifu_valid,
   output logic               idu_ready,
   input  logic [XLEN-1:0]    pc_in,
   input  logic [31:0]        instr_in,
   input  logic               flush,
   input  logic               exu_ready,
   output logic               idu_valid,
   output logic [XLEN-1:0]    pc_out,
   output logic [31:0]        instr_out,
   output logic [6:0]         opcode,
   output logic [RADDR_W-1:0] rd,
   output logic [RADDR_W-1:0] rs1,
   output logic [RADDR_W-1:0] rs2,
   output logic [2:0]         funct3,
   output logic [6:0]         funct7,
   output logic [XLEN-1:0]    imm,
   output logic [2:0]         imm_type,
   output logic               reg_wen,
   output logic               illegal
);

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_OP     = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic            v;
   logic [XLEN-1:0] pc_r;
   logic [31:0]     ir_r;
   logic            accept;
   logic            drain;

   // Ready looks through to exu_ready so that a full entry can be replaced in
   // the same cycle it drains, which sustains one instruction per cycle.
   assign idu_ready = rst & (~v | exu_ready);
   assign accept    = ifu_valid & idu_ready;
   assign drain     = v & exu_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v    <= 1'b0;
         pc_r <= '0;
         ir_r <= NOP;
      end else if (flush) begin
         // The held registers keep their contents; only the valid bit is dropped.
         v <= 1'b0;
      end else if (accept) begin
         pc_r <= pc_in;
         ir_r <= instr_in;
         v    <= 1'b1;
      end else if (drain) begin
         v <= 1'b0;
      end
   end

   assign idu_valid = v;
   assign pc_out    = pc_r;
   assign instr_out = ir_r;

   // Decode works on the held word only, so outputs stay put while stalled.
   assign opcode = ir_r[6:0];
   assign funct3 = ir_r[14:12];
   assign funct7 = ir_r[31:25];
   assign rd     = RADDR_W'(ir_r[11:7]);
   assign rs1    = RADDR_W'(ir_r[19:15]);
   assign rs2    = RADDR_W'(ir_r[24:20]);

   logic signed [31:0] imm32;
   imm_type_e          ty;
   logic               op_known;
   logic               writes_rd;
   logic               sgn;

   always_comb begin
      sgn       = ir_r[31];
      imm32     = '0;
      ty        = IMM_NONE;
      op_known  = 1'b0;
      writes_rd = 1'b0;
      case (ir_r[6:0])
         OP_LOAD, OP_IMM, OP_JALR: begin
            op_known  = 1'b1;
            writes_rd = 1'b1;
            ty        = IMM_I;
            imm32     = {{20{sgn}}, ir_r[31:20]};
         end
         OP_SYSTEM: begin
            op_known  = 1'b1;
            writes_rd = (ir_r[14:12] != 3'd0);
            ty        = IMM_I;
            imm32     = {{20{sgn}}, ir_r[31:20]};
         end
         OP_STORE: begin
            op_known = 1'b1;
            ty       = IMM_S;
            imm32    = {{20{sgn}}, ir_r[31:25], ir_r[11:7]};
         end
         OP_BRANCH: begin
            op_known = 1'b1;
            ty       = IMM_B;
            imm32    = {{19{sgn}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            op_known  = 1'b1;
            writes_rd = 1'b1;
            ty        = IMM_U;
            imm32     = {ir_r[31:12], 12'b0};
         end
         OP_JAL: begin
            op_known  = 1'b1;
            writes_rd = 1'b1;
            ty        = IMM_J;
            imm32     = {{11{sgn}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
         end
         OP_OP: begin
            // Only the base (0x00) and SUB/SRA (0x20) funct7 values exist in RV32I.
            op_known  = (ir_r[31:25] == 7'h00) || (ir_r[31:25] == 7'h20);
            writes_rd = 1'b1;
         end
         default: begin
            op_known = 1'b0;
         end
      endcase
   end

   assign illegal  = (ir_r[1:0] != 2'b11) | ~op_known;
   assign reg_wen  = writes_rd & ~illegal & (ir_r[11:7] != 5'd0);
   assign imm_type = ty;
   assign imm      = XLEN'(imm32);

endmodule

// File: tb/tb_idu_stage.sv
module tb_idu_stage;

   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic               ifu_valid;
   logic               idu_ready;
   logic [XLEN-1:0]    pc_in;
   logic [31:0]        instr_in;
   logic               flush;
   logic               exu_ready;
   logic               idu_valid;
   logic [XLEN-1:0]    pc_out;
   logic [31:0]        instr_out;
   logic [6:0]         opcode;
   logic [RADDR_W-1:0] rd, rs1, rs2;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic [XLEN-1:0]    imm;
   logic [2:0]         imm_type;
   logic               reg_wen;
   logic               illegal;

   idu_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
      .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .idu_ready(idu_ready),
      .pc_in(pc_in), .instr_in(instr_in), .flush(flush), .exu_ready(exu_ready),
      .idu_valid(idu_valid), .pc_out(pc_out), .instr_out(instr_out),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
      .funct7(funct7), .imm(imm), .imm_type(imm_type), .reg_wen(reg_wen),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   // Reference state: valid bit, held pc and held word.
   bit          m_v;
   logic [31:0] m_pc;
   logic [31:0] m_ir;
   int          transfers;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference decode straight from the RV32I field definitions, with plain
   // integer arithmetic for the immediates.
   function automatic void ref_dec(input logic [31:0] w, output logic [31:0] rimm,
                                   output int ty, output bit wen, output bit ill);
      int op, f3, f7, s, v;
      op = int'(w & 32'h7F);
      f3 = int'((w >> 12) & 7);
      f7 = int'(w >> 25);
      s  = w;              // signed view of the word
      ill = ((w & 3) != 3) ||
            !(op inside {'h03, 'h13, 'h17, 'h23, 'h33, 'h37, 'h63, 'h67, 'h6F, 'h73}) ||
            (op == 'h33 && !(f7 inside {'h00, 'h20}));
      ty = 0;
      v  = 0;
      if (op inside {'h03, 'h13, 'h67, 'h73}) begin
         ty = 1;
         v  = s >>> 20;
      end else if (op == 'h23) begin
         ty = 2;
         v  = (s >>> 25) * 32 + int'((w >> 7) & 31);
      end else if (op == 'h63) begin
         ty = 3;
         v  = (w[31] ? -4096 : 0) + int'((w >> 7) & 1) * 2048
              + int'((w >> 25) & 63) * 32 + int'((w >> 8) & 15) * 2;
      end else if (op inside {'h37, 'h17}) begin
         ty = 4;
         v  = int'(w & 32'hFFFF_F000);
      end else if (op == 'h6F) begin
         ty = 5;
         v  = (w[31] ? -(1 << 20) : 0) + int'((w >> 12) & 255) * 4096
              + int'((w >> 20) & 1) * 2048 + int'((w >> 21) & 1023) * 2;
      end
      rimm = v;
      wen = ((op inside {'h03, 'h13, 'h33, 'h37, 'h17, 'h6F, 'h67}) || (op == 'h73 && f3 != 0))
            && ((w >> 7) & 31) != 0 && !ill;
   endfunction

   task automatic compare_all();
      logic [31:0] e_imm;
      int          e_ty;
      bit          e_wen, e_ill;
      ref_dec(m_ir, e_imm, e_ty, e_wen, e_ill);
      chk("idu_ready", idu_ready, rst && (!m_v || exu_ready));
      chk("idu_valid", idu_valid, m_v);
      chk("pc_out",    pc_out,    m_pc);
      chk("instr_out", instr_out, m_ir);
      chk("opcode",    opcode,    m_ir & 32'h7F);
      chk("rd",        rd,        (m_ir >> 7) & 31);
      chk("rs1",       rs1,       (m_ir >> 15) & 31);
      chk("rs2",       rs2,       (m_ir >> 20) & 31);
      chk("funct3",    funct3,    (m_ir >> 12) & 7);
      chk("funct7",    funct7,    m_ir >> 25);
      chk("imm",       imm,       e_imm);
      chk("imm_type",  imm_type,  e_ty);
      chk("reg_wen",   reg_wen,   e_wen);
      chk("illegal",   illegal,   e_ill);
   endtask

   // One cycle: advance the model across the rising edge with the inputs that
   // were applied, then apply new inputs at the falling edge and check.
   task automatic cyc(input bit r, input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                      input bit fl, input bit er);
      @(posedge clk);
      if (rst) begin
         if (flush) m_v = 0;
         else if (ifu_valid && (!m_v || exu_ready)) begin
            if (m_v) transfers++;
            m_v = 1; m_pc = pc_in; m_ir = instr_in;
         end else if (m_v && exu_ready) begin
            transfers++;
            m_v = 0;
         end
      end
      @(negedge clk);
      rst = r; ifu_valid = iv; pc_in = pc; instr_in = ins; flush = fl; exu_ready = er;
      if (!r) begin
         m_v = 0; m_pc = '0; m_ir = 32'h13;
      end
      #1;
      compare_all();
   endtask

   localparam logic [6:0] OPS [10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
                                        7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
   logic [31:0] ill_words [4] = '{32'h0000_000B, 32'h4000_0033, 32'h7E00_0033, 32'h0000_0000};
   bit          ill_exp   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      logic [31:0] r, w;
      int          t0;
      rst = 0; ifu_valid = 1; pc_in = '0; instr_in = '0; flush = 0; exu_ready = 0;
      m_v = 0; m_pc = '0; m_ir = 32'h13; transfers = 0;

      // Reset held with fetch offering.
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 32'h1234_5678, 32'h0000_0033, 0, 1);
         chk("rst_ready", idu_ready, 0);
         chk("rst_valid", idu_valid, 0);
         chk("rst_instr", instr_out, 32'h13);
      end
      cyc(1, 0, 0, 0, 0, 0);
      chk("release_ready", idu_ready, 1);

      // Streaming.
      cyc(1, 1, 32'h8000_0000, 32'h0050_0093, 0, 1);
      cyc(1, 1, 32'h8000_0004, 32'hFFF0_0113, 0, 1);
      chk("s1_valid", idu_valid, 1);
      chk("s1_pc",    pc_out, 32'h8000_0000);
      chk("s1_rd",    rd, 1);
      chk("s1_imm",   imm, 5);
      chk("s1_type",  imm_type, 1);
      chk("s1_wen",   reg_wen, 1);
      cyc(1, 1, 32'h8000_0008, 32'h0011_2223, 0, 1);
      chk("s2_rd",    rd, 2);
      chk("s2_imm",   imm, 32'hFFFF_FFFF);
      chk("s2_wen",   reg_wen, 1);

      // Backpressure for four cycles on the store.
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 32'h8000_000C, $urandom(), 0, 0);
         chk("bp_ready", idu_ready, 0);
         chk("bp_pc",    pc_out, 32'h8000_0008);
         chk("bp_instr", instr_out, 32'h0011_2223);
         chk("bp_imm",   imm, 4);
         chk("bp_type",  imm_type, 2);
         chk("bp_wen",   reg_wen, 0);
         chk("bp_rs1",   rs1, 2);
         chk("bp_rs2",   rs2, 1);
      end
      t0 = transfers;
      cyc(1, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 1);
      chk("bp_one_xfer", transfers - t0, 1);
      chk("bp_empty",    idu_valid, 0);

      // Branch and jump immediates.
      cyc(1, 1, 32'h8000_0010, 32'hFE00_0EE3, 0, 1);
      cyc(1, 1, 32'h8000_0014, 32'h0080_00EF, 0, 1);
      chk("b_imm",  imm, 32'hFFFF_FFFC);
      chk("b_type", imm_type, 3);
      cyc(1, 0, 0, 0, 0, 1);
      chk("j_imm",  imm, 8);
      chk("j_type", imm_type, 5);
      chk("j_rd",   rd, 1);
      chk("j_wen",  reg_wen, 1);

      // Flush with an entry held and another offered.
      cyc(1, 1, 32'h8000_0020, 32'h0010_0093, 0, 0);
      t0 = transfers;
      cyc(1, 1, 32'h8000_0024, 32'h0020_0113, 1, 0);
      chk("fl_held", idu_valid, 1);
      cyc(1, 0, 0, 0, 0, 1);
      chk("fl_valid", idu_valid, 0);
      cyc(1, 0, 0, 0, 0, 1);
      chk("fl_no_xfer", transfers - t0, 0);

      // Illegal encodings.
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 32'h9000_0000 + 4 * i, ill_words[i], 0, 1);
         if (i > 0) chk("illegal_word", illegal, ill_exp[i-1]);
      end
      cyc(1, 0, 0, 0, 0, 1);
      chk("illegal_word", illegal, ill_exp[3]);
      chk("illegal_wen0", reg_wen, 0);

      // Random traffic, including occasional mid-stream reset.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom();
         if ($urandom_range(0, 3) != 0) w = {r[31:7], OPS[$urandom_range(0, 9)]};
         else w = $urandom();
         cyc($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1, $urandom(), w,
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
